// File: rtl/demux_1ton_frame.sv
// Registered 1-to-N_OUT word demultiplexer / frame gatherer for the FFT input path.
// A serial sample stream is written onto N_OUT lanes, either addressed by sel or
// auto-sequenced by an internal write pointer. A complete frame is offered downstream
// with a valid/ready handshake.
// Optional feature: define DEMUX_ERR_DET_EN to enable the sticky err flag for
// addressed-mode overwrites and out-of-range sel values.
module demux_1ton_frame #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned N_OUT     = 4,
   localparam int unsigned SEL_W    = $clog2(N_OUT)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WORD_SIZE-1:0]       in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SEL_W-1:0]           sel,
   input  logic                       auto_mode,
   input  logic                       clear,
   output logic [N_OUT*WORD_SIZE-1:0] out_data,
   output logic [N_OUT-1:0]           lane_valid,
   output logic                       frame_valid,
   input  logic                       frame_ready,
   output logic                       err
);

   localparam logic [SEL_W:0]   NumLanes = (SEL_W + 1)'(N_OUT);
   localparam logic [SEL_W-1:0] LastLane = SEL_W'(N_OUT - 1);

   logic [N_OUT-1:0][WORD_SIZE-1:0] data_q, data_d;
   logic [N_OUT-1:0]                lane_valid_q, lane_valid_d;
   logic [SEL_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [SEL_W-1:0]                base_ptr;
   logic [SEL_W-1:0]                lane;
   logic                            accept;
   logic                            consume;
   logic                            lane_ok;

   assign frame_valid = &lane_valid_q;
   assign in_ready    = ~frame_valid | frame_ready;
   assign accept      = in_valid & in_ready;
   assign consume     = frame_valid & frame_ready;

   // A word accepted together with a consume belongs to the new frame, so the
   // auto pointer is seen as already rewound to lane 0.
   assign base_ptr = consume ? '0 : wr_ptr_q;
   assign lane     = auto_mode ? base_ptr : sel;
   // Only matters for non power-of-two N_OUT, where sel can name a missing lane.
   assign lane_ok  = {1'b0, lane} < NumLanes;

   assign out_data   = data_q;
   assign lane_valid = lane_valid_q;

   // Next-state for lane data, lane valid bits and the auto write pointer.
   always_comb begin
      data_d       = data_q;
      lane_valid_d = lane_valid_q;
      wr_ptr_d     = wr_ptr_q;
      if (clear) begin
         // Clear wins over accept and consume; out_data is deliberately kept.
         lane_valid_d = '0;
         wr_ptr_d     = '0;
      end else begin
         if (consume) begin
            lane_valid_d = '0;
            wr_ptr_d     = '0;
         end
         if (accept && lane_ok) begin
            data_d[lane]       = in_data;
            lane_valid_d[lane] = 1'b1;
         end
         if (accept && auto_mode) begin
            // Saturate on the last lane; frame_valid then blocks further accepts.
            wr_ptr_d = (base_ptr == LastLane) ? base_ptr : base_ptr + SEL_W'(1);
         end
      end
   end

   // Frame state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q       <= '0;
         lane_valid_q <= '0;
         wr_ptr_q     <= '0;
      end else begin
         data_q       <= data_d;
         lane_valid_q <= lane_valid_d;
         wr_ptr_q     <= wr_ptr_d;
      end
   end

`ifdef DEMUX_ERR_DET_EN
   logic err_q, err_d;
   logic lane_was_valid;
   logic addr_fault;

   // A lane valid in the frame being consumed is not an overwrite of the new frame.
   assign lane_was_valid = lane_ok ? (lane_valid_q[lane] & ~consume) : 1'b0;
   assign addr_fault     = accept & ~auto_mode & (~lane_ok | lane_was_valid);

   // Sticky error flag, cleared only by clear or reset.
   always_comb begin
      err_d = err_q | addr_fault;
      if (clear) begin
         err_d = 1'b0;
      end
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
